// File: rtl/video_capture_pkg.sv
// Shared definitions for the frame-grabber: FSM states, luma weights and the
// reference 1080p timing constants used by stream sources.
package video_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam int unsigned GRAY_COEF_R = 77;
    localparam int unsigned GRAY_COEF_G = 150;
    localparam int unsigned GRAY_COEF_B = 29;

    localparam int unsigned STD_H_ACTIVE = 1920;
    localparam int unsigned STD_H_FP     = 88;
    localparam int unsigned STD_H_SYNC   = 44;
    localparam int unsigned STD_H_BP     = 148;
    localparam int unsigned STD_V_ACTIVE = 1080;
    localparam int unsigned STD_V_FP     = 4;
    localparam int unsigned STD_V_SYNC   = 5;
    localparam int unsigned STD_V_BP     = 36;

endpackage

// File: rtl/video_capture_if.sv
// Parallel RGB video stream with DE/HSYNC/VSYNC, as delivered by a camera or HDMI receiver.
interface video_capture_if;

    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       de;
    logic       hsync;
    logic       vsync;

    modport master (output r, g, b, de, hsync, vsync);
    modport slave  (input  r, g, b, de, hsync, vsync);

endinterface

// File: rtl/video_capture_rgb2gray.sv
// Registered RGB to 8-bit luma: (77r + 150g + 29b) >> 8, truncated.
module rgb2gray
    import video_capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    output logic [7:0] gray_o
);

    logic [15:0] acc;
    logic [7:0]  gray_q;

    // Weights sum to 256, so the 16-bit sum never overflows and grey maps to itself.
    always_comb begin
        acc = 16'(GRAY_COEF_R) * {8'd0, r_i}
            + 16'(GRAY_COEF_G) * {8'd0, g_i}
            + 16'(GRAY_COEF_B) * {8'd0, b_i};
    end

    always_ff @(posedge clk) begin
        if (rst) gray_q <= '0;
        else     gray_q <= 8'(acc >> 8);
    end

    assign gray_o = gray_q;

endmodule

// File: rtl/video_capture.sv
// Single-frame grabber: crops an H x V window of the incoming stream to grey
// and writes it into the frame-buffer BRAM at line*H + column.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int unsigned H           = 500,
    parameter int unsigned V           = 500,
    parameter int unsigned ADDR_W      = 19,
    parameter logic        SYNC_ACTIVE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    video_capture_if.slave    vid,
    input  logic              start,
    output logic [ADDR_W-1:0] addra,
    output logic [7:0]        dina,
    output logic              wea,
    output logic              ena,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);

    localparam int unsigned       XW     = $clog2(H + 1);
    localparam int unsigned       YW     = $clog2(V + 1);
    localparam logic [XW-1:0]     H_X    = XW'(H);
    localparam logic [YW-1:0]     V_LAST = YW'(V - 1);
    localparam logic [ADDR_W-1:0] H_A    = ADDR_W'(H);

    state_t            state_q, state_d;
    logic [7:0]        r1_q, g1_q, b1_q;
    logic              de1_q, de2_q, vs1_q, vs2_q;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
    logic              wea_q, wea_d, ferr_q, ferr_d;
    logic              de_fall, vs_edge, in_window, line_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q  <= '0;
            g1_q  <= '0;
            b1_q  <= '0;
            de1_q <= 1'b0;
            de2_q <= 1'b0;
            vs1_q <= SYNC_ACTIVE;
            vs2_q <= SYNC_ACTIVE;
        end else begin
            r1_q  <= vid.r;
            g1_q  <= vid.g;
            b1_q  <= vid.b;
            de1_q <= vid.de;
            de2_q <= de1_q;
            vs1_q <= vid.vsync;
            vs2_q <= vs1_q;
        end
    end

    assign vs_edge   = (vs1_q == SYNC_ACTIVE) && (vs2_q != SYNC_ACTIVE);
    assign de_fall   = de2_q && !de1_q;
    assign in_window = (x_q < H_X) && (y_q <= V_LAST);
    // A line end that completes the window wins over a coincident vsync edge.
    assign line_done = de_fall && (y_q == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_WAIT_VS;
            ST_WAIT_VS: if (vs_edge) state_d = ST_CAPTURE;
            ST_CAPTURE: if (line_done || vs_edge) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        base_d = base_q;
        ferr_d = ferr_q;
        addr_d = addr_q;
        wea_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d    = '0;
                    y_d    = '0;
                    base_d = '0;
                    ferr_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (de1_q) begin
                    if (in_window) begin
                        wea_d  = 1'b1;
                        addr_d = base_q + ADDR_W'(x_q);
                    end
                    // Saturate at H so wide source lines cannot wrap back into the window.
                    if (x_q != H_X) x_d = x_q + 1'b1;
                end
                if (de_fall) begin
                    x_d    = '0;
                    y_d    = y_q + 1'b1;
                    base_d = base_q + H_A;
                end
                if (vs_edge && !line_done) ferr_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            base_q <= '0;
            addr_q <= '0;
            wea_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            base_q <= base_d;
            addr_q <= addr_d;
            wea_q  <= wea_d;
            ferr_q <= ferr_d;
        end
    end

    rgb2gray u_gray (
        .clk    (clk),
        .rst    (rst),
        .r_i    (r1_q),
        .g_i    (g1_q),
        .b_i    (b1_q),
        .gray_o (dina)
    );

    assign addra     = addr_q;
    assign wea       = wea_q;
    assign ena       = wea_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q == ST_WAIT_VS) || (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_video_capture.sv
// Two grabbers (4x3 and 1x1 windows) share one randomized video source and are
// checked cycle-by-cycle against a frame-level model of the expected writes.
module tb_video_capture;

    localparam int unsigned AW = 19;
    localparam int HA = 4, VA = 3, HB = 1, VB = 1;

    typedef struct {
        int id;
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic start;

    logic [AW-1:0] addra_a, addra_b;
    logic [7:0]    dina_a, dina_b;
    logic          wea_a, wea_b, ena_a, ena_b, busy_a, busy_b;
    logic          done_a, done_b, ferr_a, ferr_b;

    video_capture_if vif ();

    video_capture #(.H(HA), .V(VA), .ADDR_W(AW), .SYNC_ACTIVE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .vid(vif), .start(start),
        .addra(addra_a), .dina(dina_a), .wea(wea_a), .ena(ena_a),
        .busy(busy_a), .done(done_a), .frame_err(ferr_a)
    );

    video_capture #(.H(HB), .V(VB), .ADDR_W(AW), .SYNC_ACTIVE(1'b1)) dut_b (
        .clk(clk), .rst(rst), .vid(vif), .start(start),
        .addra(addra_b), .dina(dina_b), .wea(wea_b), .ena(ena_b),
        .busy(busy_b), .done(done_b), .frame_err(ferr_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Frame-level reference model
    string nm [2]        = '{"A", "B"};
    int    hp [2]        = '{HA, HB};
    int    vp [2]        = '{VA, VB};
    bit    armed [2]     = '{0, 0};
    bit    active [2]    = '{0, 0};
    bit    exp_err [2]   = '{0, 0};
    int    exp_done [2]  = '{-1, -1};
    int    n_done_exp [2]  = '{0, 0};
    int    n_done_seen [2] = '{0, 0};
    int    n_wr_seen [2]   = '{0, 0};
    int    last_dina_b = -1;
    wr_t   exp_q [$];

    function automatic int luma(input int r, input int g, input int b);
        return (r * 77 + g * 150 + b * 29) / 256;
    endfunction

    task automatic model_pixel(input int l, input int x, input int r, input int g, input int b);
        for (int i = 0; i < 2; i++)
            if (active[i] && l < vp[i] && x < hp[i])
                exp_q.push_back('{i, l * hp[i] + x, luma(r, g, b), cyc + 2});
    endtask

    task automatic model_vsync();
        for (int i = 0; i < 2; i++) begin
            if (active[i]) begin
                active[i]   = 0;
                exp_err[i]  = 1;
                exp_done[i] = cyc + 2;
                n_done_exp[i]++;
            end else if (armed[i]) begin
                armed[i]  = 0;
                active[i] = 1;
            end
        end
    endtask

    task automatic model_defall(input int l);
        for (int i = 0; i < 2; i++)
            if (active[i] && l + 1 == vp[i]) begin
                active[i]   = 0;
                exp_done[i] = cyc + 2;
                n_done_exp[i]++;
            end
    endtask

    task automatic model_start();
        for (int i = 0; i < 2; i++)
            if (!armed[i] && !active[i] && cyc > exp_done[i]) begin
                armed[i]   = 1;
                exp_err[i] = 0;
            end
    endtask

    task automatic model_rst();
        for (int i = 0; i < 2; i++) begin
            armed[i]   = 0;
            active[i]  = 0;
            exp_err[i] = 0;
            if (exp_done[i] > cyc) begin
                exp_done[i] = -1;
                n_done_exp[i]--;
            end
        end
        for (int j = exp_q.size() - 1; j >= 0; j--)
            if (exp_q[j].cyc > cyc) exp_q.delete(j);
    endtask

    // Output monitor, sampled mid-cycle
    logic [1:0]    wea_m, ena_m, done_m, ferr_m;
    logic [AW-1:0] addr_m [2];
    logic [7:0]    data_m [2];
    assign wea_m  = {wea_b, wea_a};
    assign ena_m  = {ena_b, ena_a};
    assign done_m = {done_b, done_a};
    assign ferr_m = {ferr_b, ferr_a};
    assign addr_m[0] = addra_a;
    assign addr_m[1] = addra_b;
    assign data_m[0] = dina_a;
    assign data_m[1] = dina_b;

    int  mon_idx;
    bit  mon_due;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            mon_idx = -1;
            for (int j = 0; j < exp_q.size(); j++)
                if (exp_q[j].id == i) begin
                    mon_idx = j;
                    break;
                end
            if (mon_idx >= 0 && exp_q[mon_idx].cyc < cyc) begin
                check_eq($sformatf("%s.write_missing_addr%0d", nm[i], exp_q[mon_idx].addr), 0, 1);
                exp_q.delete(mon_idx);
                mon_idx = -1;
            end
            mon_due = (mon_idx >= 0) && (exp_q[mon_idx].cyc == cyc);
            if (mon_due || wea_m[i]) begin
                check_eq($sformatf("%s.wea", nm[i]), wea_m[i], mon_due);
                check_eq($sformatf("%s.ena", nm[i]), ena_m[i], mon_due);
                if (mon_due && wea_m[i]) begin
                    check_eq($sformatf("%s.addra", nm[i]), addr_m[i], exp_q[mon_idx].addr);
                    check_eq($sformatf("%s.dina", nm[i]), data_m[i], exp_q[mon_idx].data);
                    n_wr_seen[i]++;
                    if (i == 1) last_dina_b = int'(data_m[i]);
                end
                if (mon_due) exp_q.delete(mon_idx);
            end
            if (done_m[i] || cyc == exp_done[i]) begin
                check_eq($sformatf("%s.done", nm[i]), done_m[i], cyc == exp_done[i]);
                if (cyc == exp_done[i])
                    check_eq($sformatf("%s.frame_err_at_done", nm[i]), ferr_m[i], exp_err[i]);
                if (done_m[i]) n_done_seen[i]++;
            end
        end
    end

    // Stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        model_start();
        tick();
        start = 1'b0;
        check_eq("A.busy_after_start", busy_a, armed[0]);
        check_eq("A.frame_err_after_start", ferr_a, exp_err[0]);
    endtask

    task automatic post_rst_checks();
        check_eq("A.busy_after_rst", busy_a, 0);
        check_eq("A.done_after_rst", done_a, 0);
        check_eq("A.wea_after_rst", wea_a, 0);
    endtask

    task automatic send_frame(input int aw, input int ah, input int mode, input int start_line,
                              input int rst_line, input int rst_col, input int fixed_rgb);
        int r, g, b;
        bit rst_chk;
        rst_chk = 0;
        tick();
        vif.vsync = 1'b1;
        model_vsync();
        repeat (2) tick();
        tick();
        vif.vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < ah; l++) begin
            for (int x = 0; x < aw; x++) begin
                tick();
                if (rst_chk) begin
                    post_rst_checks();
                    rst_chk = 0;
                end
                if (mode == 1) begin
                    r = (x + 16 * l) & 255;
                    g = r;
                    b = r;
                end else begin
                    r = int'($urandom_range(0, 255));
                    g = int'($urandom_range(0, 255));
                    b = int'($urandom_range(0, 255));
                end
                if (fixed_rgb >= 0 && l == 0 && x == 0) begin
                    r = (fixed_rgb >> 16) & 255;
                    g = (fixed_rgb >> 8) & 255;
                    b = fixed_rgb & 255;
                end
                vif.de = 1'b1;
                vif.r  = 8'(r);
                vif.g  = 8'(g);
                vif.b  = 8'(b);
                model_pixel(l, x, r, g, b);
                start = (l == start_line) && (x == 1);
                if (start) model_start();
                rst = (l == rst_line) && (x == rst_col);
                if (rst) begin
                    model_rst();
                    rst_chk = 1;
                end
            end
            tick();
            if (rst_chk) begin
                post_rst_checks();
                rst_chk = 0;
            end
            vif.de = 1'b0;
            start  = 1'b0;
            rst    = 1'b0;
            model_defall(l);
            tick();
            vif.hsync = 1'b1;
            tick();
            vif.hsync = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (2) tick();
    endtask

    task automatic scenario_end(input string tag);
        check_eq({tag, ".pending_writes"}, exp_q.size(), 0);
        check_eq({tag, ".A.done_count"}, n_done_seen[0], n_done_exp[0]);
        check_eq({tag, ".B.done_count"}, n_done_seen[1], n_done_exp[1]);
        check_eq({tag, ".A.frame_err"}, ferr_a, exp_err[0]);
    endtask

    int colours [4] = '{32'hFF0000, 32'h00FF00, 32'h0000FF, 32'hFFFFFF};
    int weights [4] = '{76, 149, 28, 255};
    int wr_before;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        vif.r     = '0;
        vif.g     = '0;
        vif.b     = '0;
        vif.de    = 1'b0;
        vif.hsync = 1'b0;
        vif.vsync = 1'b0;

        // Reset held with a live, random stream
        repeat (3) begin
            tick();
            check_eq("rst.addra", addra_a, 0);
            check_eq("rst.dina", dina_a, 0);
            check_eq("rst.wea", wea_a, 0);
            check_eq("rst.ena", ena_a, 0);
            check_eq("rst.busy", busy_a, 0);
            check_eq("rst.done", done_a, 0);
            check_eq("rst.frame_err", ferr_a, 0);
            check_eq("rst.B.wea", wea_b, 0);
            vif.de    = 1'($urandom_range(0, 1));
            vif.vsync = 1'($urandom_range(0, 1));
            vif.r     = 8'($urandom_range(0, 255));
            vif.g     = 8'($urandom_range(0, 255));
            vif.b     = 8'($urandom_range(0, 255));
            start     = 1'($urandom_range(0, 1));
        end
        tick();
        rst       = 1'b0;
        start     = 1'b0;
        vif.de    = 1'b0;
        vif.vsync = 1'b0;
        repeat (4) tick();

        // Gradient frame, 8x6 source
        pulse_start();
        send_frame(8, 6, 1, -1, -1, -1, -1);
        scenario_end("gradient");
        check_eq("gradient.A.writes", n_wr_seen[0], HA * VA);

        // Colour weights through the 1x1 window
        for (int c = 0; c < 4; c++) begin
            pulse_start();
            send_frame(4, 3, 0, -1, -1, -1, colours[c]);
            check_eq($sformatf("weight%0d.B.dina", c), last_dina_b, weights[c]);
        end
        scenario_end("weights");

        // Start during active line 2: capture begins at the next frame
        send_frame(6, 4, 0, 2, -1, -1, -1);
        send_frame(6, 4, 0, -1, -1, -1, -1);
        scenario_end("late_start");

        // Frame with only 2 lines ends on the next vsync
        pulse_start();
        wr_before = n_wr_seen[0];
        send_frame(6, 2, 0, -1, -1, -1, -1);
        send_frame(6, 4, 0, -1, -1, -1, -1);
        scenario_end("short_frame");
        check_eq("short_frame.A.writes", n_wr_seen[0] - wr_before, 2 * HA);
        check_eq("short_frame.A.frame_err_set", ferr_a, 1);
        pulse_start();
        check_eq("short_frame.A.frame_err_cleared", ferr_a, 0);
        send_frame(6, 4, 0, -1, -1, -1, -1);
        scenario_end("after_short");

        // Reset after the fifth write, then a full re-capture
        pulse_start();
        wr_before = n_wr_seen[0];
        send_frame(8, 4, 0, -1, 1, 2, -1);
        check_eq("mid_rst.A.writes", n_wr_seen[0] - wr_before, 5);
        pulse_start();
        send_frame(8, 4, 0, -1, -1, -1, -1);
        scenario_end("mid_rst");

        // Random geometry, including lines narrower than the window
        repeat (5) begin
            pulse_start();
            send_frame(int'($urandom_range(2, 8)), int'($urandom_range(3, 5)), 0, -1, -1, -1, -1);
        end
        scenario_end("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/video_capture.md
# video_capture

Frame-grabber that receives a parallel RGB video stream with DE/HSYNC/VSYNC and writes a cropped H×V window of 8-bit grayscale pixels into the frame-buffer BRAM write port. It is the input-side counterpart of the display generator: the camera/HDMI-RX stream enters here, and the edge-detection core and display path read the same buffer. Capture is single-frame, armed by `start`, and signalled complete by `done`.

## Interface
- `H`, 500, window width in pixels (columns 0..H-1 of each active line)
- `V`, 500, window height in lines (active lines 0..V-1 of the frame)
- `ADDR_W`, 19, BRAM address width; H*V ≤ 2^ADDR_W required
- `SYNC_ACTIVE`, 1, asserted level of `hsync`/`vsync`
- `clk`  in  1  pixel clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `r`, `g`, `b`  in  8 each  pixel colour, valid when `de`=1
- `de`  in  1  data enable; high during active pixels
- `hsync`  in  1  horizontal sync (unused for counting; sampled for alignment only)
- `vsync`  in  1  vertical sync; frame boundary = transition into SYNC_ACTIVE
- `start`  in  1  arm one capture; level, sampled only in IDLE
- `addra`  out  ADDR_W  BRAM write address = line*H + column
- `dina`  out  8  grayscale pixel
- `wea`  out  1  write strobe, one cycle per pixel
- `ena`  out  1  BRAM enable; equals `wea`
- `busy`  out  1  high in WAIT_VS and CAPTURE
- `done`  out  1  one-cycle pulse at end of capture
- `frame_err`  out  1  sticky: frame ended before V lines; cleared on accepted `start`

## Operation
- Reset values: `addra`=0, `dina`=0, `wea`=0, `ena`=0, `busy`=0, `done`=0, `frame_err`=0, state IDLE, all counters 0.
- Stage 1 registers `r,g,b,de,vsync`; edges detected on registered copies.
- FSM:
  - IDLE: `start`=1 → WAIT_VS, clear `frame_err`, counters 0.
  - WAIT_VS: vsync edge into SYNC_ACTIVE → CAPTURE. No writes.
  - CAPTURE: per `de`=1 cycle, column counter x increments; write issued if x<H and line y<V. On `de` falling edge: x←0, y←y+1, line_base←line_base+H. When y reaches V → DONE. vsync edge into SYNC_ACTIVE with y<V → set `frame_err`, → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `start` outside IDLE ignored. Pixels beyond column H-1 or line V-1 dropped.
- Address = line_base + x (adder, no multiplier); line_base width ADDR_W.
- Gray = (77·r + 150·g + 29·b) >> 8, 16-bit accumulate, result 8 bits, no rounding; r=g=b=X yields exactly X.
- `rst` mid-capture: next cycle IDLE, `wea`=0, no `done`, no partial-frame flag.

## Timing
- Pixel presented on edge N → `wea`/`addra`/`dina` valid after edge N+2 (stage 1 input reg, stage 2 gray+address reg).
- `done` asserted the cycle after the last window write's `wea`, or the cycle after the vsync edge is detected on error.
- Throughput: one pixel per clock, no stalls; BRAM write accepted same cycle.
- Simultaneous `de` fall and vsync edge: line end processed first (y increments), then V check.

## Structure
- Shared `video_pkg`: FSM state encoding (IDLE, WAIT_VS, CAPTURE, DONE), gray coefficients 77/150/29, standard timing constants (1920×1080: 1920/88/44/148, 1080/4/5/36) used by the bench source model.
- One sub-module: `rgb2gray` (registered, 1-cycle, 8-bit ×3 in, 8-bit out).

## Test plan
- Reset: hold `rst` 3 cycles with active stream → all outputs 0, `busy`=0, no `wea`.
- H=4, V=3, source 8×6 active, r=g=b=x+16·y, `start` before frame → 12 writes, addresses 0..11, `dina`=x+16·y, one `done` after line 2's DE fall, `frame_err`=0.
- Colour weights, H=V=1: (255,0,0)→76; (0,255,0)→149; (0,0,255)→28; (255,255,255)→255.
- `start` during active line 2 → no writes until next vsync edge; first write addr 0, data from line 0 of next frame.
- H=4, V=3, vsync edge after 2 lines → 8 writes, `frame_err`=1, `done` pulse, IDLE; next `start` clears `frame_err`.
- `rst` pulsed after 5 writes → `wea`=0 next cycle, no `done`, state IDLE; re-`start` captures full frame from addr 0.
